// File: rtl/aes192_round_key_sequencer.sv
// AES-192 round-key sequencer: captures an expanded key set and streams the
// 13 round keys over a valid/ready handshake, forward or reverse.
module aes192_round_key_sequencer #(
    parameter int NR     = 12,
    parameter int KEYS_W = 2496
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [KEYS_W-1:0] keys,
    input  logic              decrypt,
    input  logic              flush,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk,
    output logic [3:0]        rk_index,
    output logic              rk_last,
    output logic              busy
);

    localparam int NK      = NR + 1;
    localparam int KEEP_LO = KEYS_W - 128 * NK;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [3:0] IDX_FIRST = 4'd0;
    localparam logic [3:0] IDX_LAST  = 4'(NR);

    function automatic logic [127:0] round_key_slice(input logic [KEYS_W-1:0] v, input int k);
        return v[KEYS_W-1-128*k -: 128];
    endfunction

    logic [0:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic         dec_q, dec_d;
    logic         load_en_s;
    logic [3:0]   term_s;
    logic [127:0] key_q [NK];
    logic [127:0] key_d [NK];

    logic         load_ready_q, load_ready_d;
    logic         rk_valid_q, rk_valid_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rk_index_q, rk_index_d;
    logic         rk_last_q, rk_last_d;

    // The tail of the expanded key is never used by the cipher rounds.
    logic unused_keys_s;
    assign unused_keys_s = ^keys[KEEP_LO-1:0];

    assign term_s = dec_q ? IDX_FIRST : IDX_LAST;

    // Next-state, index and direction control; flush overrides both handshakes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dec_d     = dec_q;
        load_en_s = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        load_en_s = 1'b1;
                        dec_d     = decrypt;
                        idx_d     = decrypt ? IDX_LAST : IDX_FIRST;
                        state_d   = ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (rk_ready) begin
                        if (idx_q == term_s) begin
                            state_d = ST_IDLE;
                        end else if (dec_q) begin
                            idx_d = idx_q - 4'd1;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Key storage next value: replaced only on an accepted load.
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            if (load_en_s) begin
                key_d[k] = round_key_slice(keys, k);
            end else begin
                key_d[k] = key_q[k];
            end
        end
    end

    // Output next values, so every output leaves a flop.
    always_comb begin
        load_ready_d = 1'b1;
        rk_valid_d   = 1'b0;
        rk_d         = 128'd0;
        rk_index_d   = 4'd0;
        rk_last_d    = 1'b0;
        if (state_d == ST_STREAM) begin
            load_ready_d = 1'b0;
            rk_valid_d   = 1'b1;
            rk_d         = key_d[idx_d];
            rk_index_d   = idx_d;
            rk_last_d    = (idx_d == (dec_d ? IDX_FIRST : IDX_LAST));
        end else begin
            load_ready_d = 1'b1;
        end
    end

    // State, key storage and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            dec_q        <= 1'b0;
            load_ready_q <= 1'b1;
            rk_valid_q   <= 1'b0;
            rk_q         <= 128'd0;
            rk_index_q   <= 4'd0;
            rk_last_q    <= 1'b0;
            for (int k = 0; k < NK; k++) begin
                key_q[k] <= 128'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dec_q        <= dec_d;
            load_ready_q <= load_ready_d;
            rk_valid_q   <= rk_valid_d;
            rk_q         <= rk_d;
            rk_index_q   <= rk_index_d;
            rk_last_q    <= rk_last_d;
            for (int k = 0; k < NK; k++) begin
                key_q[k] <= key_d[k];
            end
        end
    end

    assign load_ready = load_ready_q;
    assign rk_valid   = rk_valid_q;
    assign rk         = rk_q;
    assign rk_index   = rk_index_q;
    assign rk_last    = rk_last_q;
    assign busy       = rk_valid_q;

endmodule

// File: tb/tb_aes192_round_key_sequencer.sv
// Scoreboard bench for aes192_round_key_sequencer using the FIPS-197 AES-192
// expansion of key 000102..17, built here from an S-box model.
module tb_aes192_round_key_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [2495:0] keys;
    logic          decrypt;
    logic          flush;
    logic          rk_valid;
    logic          rk_ready;
    logic [127:0]  rk;
    logic [3:0]    rk_index;
    logic          rk_last;
    logic          busy;

    aes192_round_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .keys       (keys),
        .decrypt    (decrypt),
        .flush      (flush),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk         (rk),
        .rk_index   (rk_index),
        .rk_last    (rk_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1  = 128'h10111213141516175846f2f95c43f4fe;
    localparam logic [127:0] K12 = 128'ha4970a331a78dc09c418c271e3a41d5d;

    typedef struct packed {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
    } beat_t;
    beat_t sb[$];

    logic [2047:0] sbox_bits;
    logic [31:0]   w [52];
    logic [2495:0] ka;
    logic [2495:0] kb;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sub8(input logic [7:0] b);
        return sbox_bits[2047-8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sub8(x[31:24]), sub8(x[23:16]), sub8(x[15:8]), sub8(x[7:0])};
    endfunction

    task automatic build_keys();
        logic [31:0] t;
        w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b;
        w[3] = 32'h0c0d0e0f; w[4] = 32'h10111213; w[5] = 32'h14151617;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {(8'h01 << (i/6 - 1)), 24'h000000};
            end
            w[i] = w[i-6] ^ t;
        end
        for (int i = 0; i < 26; i++) begin
            ka[32*i +: 32] = 32'hdeadbeef;
            kb[32*i +: 32] = $urandom;
        end
        for (int i = 0; i < 52; i++) begin
            ka[2495-32*i -: 32] = w[i];
            kb[2495-32*i -: 32] = w[i] ^ 32'hffff0000 ^ 32'(i);
        end
    endtask

    task automatic push_set(input logic [2495:0] v, input logic dec);
        beat_t e;
        int    k;
        for (int b = 0; b < 13; b++) begin
            k      = dec ? 12 - b : b;
            e.rk   = v[2495-128*k -: 128];
            e.idx  = 4'(k);
            e.last = (b == 12);
            sb.push_back(e);
        end
    endtask

    task automatic do_load(input logic [2495:0] v, input logic dec);
        int n = 0;
        while (!load_ready && n < 50) begin
            tick();
            n++;
        end
        chk("load_ready_wait", 128'(load_ready), 128'd1);
        keys       = v;
        decrypt    = dec;
        load_valid = 1'b1;
        push_set(v, dec);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((sb.size() != 0 || !load_ready) && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 128'(sb.size() == 0 && load_ready), 128'd1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_rk_valid"}, 128'(rk_valid), 128'd0);
        chk({nm, "_load_ready"}, 128'(load_ready), 128'd1);
        chk({nm, "_busy"}, 128'(busy), 128'd0);
        chk({nm, "_rk"}, rk, 128'd0);
        chk({nm, "_rk_index"}, 128'(rk_index), 128'd0);
        chk({nm, "_rk_last"}, 128'(rk_last), 128'd0);
    endtask

    // Monitor: pops the scoreboard on each accepted beat, checks stall stability.
    beat_t        mon_e;
    logic         stalled = 1'b0;
    logic [127:0] st_rk;
    logic [3:0]   st_idx;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !flush) begin
                if (stalled && rk_valid) begin
                    chk("stall_rk", rk, st_rk);
                    chk("stall_idx", 128'(rk_index), 128'(st_idx));
                end
                stalled = 1'b0;
                if (rk_valid && rk_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual_idx=%0d expected=no_beat", rk_index);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_rk", rk, mon_e.rk);
                        chk("sb_idx", 128'(rk_index), 128'(mon_e.idx));
                        chk("sb_last", 128'(rk_last), 128'(mon_e.last));
                    end
                end else if (rk_valid) begin
                    stalled = 1'b1;
                    st_rk   = rk;
                    st_idx  = rk_index;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int acc [4];
    int nw;

    initial begin
        sbox_bits = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        build_keys();
        rst = 1'b1; load_valid = 1'b0; keys = '0; decrypt = 1'b0; flush = 1'b0; rk_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        chk("reset_release_load_ready", 128'(load_ready), 128'd1);

        // Forward stream with hand-computed round keys.
        do_load(ka, 1'b0);
        for (int b = 0; b < 13; b++) begin
            chk("fwd_valid", 128'(rk_valid), 128'd1);
            chk("fwd_idx", 128'(rk_index), 128'(b));
            if (b == 0) chk("fwd_beat0", rk, K0);
            if (b == 1) chk("fwd_beat1", rk, K1);
            if (b == 12) chk("fwd_beat12", rk, K12);
            chk("fwd_last", 128'(rk_last), 128'(b == 12));
            tick();
        end
        check_idle("fwd_end");
        chk("fwd_sb_empty", 128'(sb.size()), 128'd0);

        // Reverse stream.
        do_load(ka, 1'b1);
        for (int b = 0; b < 13; b++) begin
            chk("rev_idx", 128'(rk_index), 128'(12 - b));
            if (b == 0) chk("rev_first", rk, K12);
            if (b == 12) chk("rev_final", rk, K0);
            chk("rev_last", 128'(rk_last), 128'(b == 12));
            tick();
        end
        check_idle("rev_end");

        // Random backpressure with ignored mid-stream load pulses.
        do_load(ka, 1'b0);
        nw = 0;
        while (busy && nw < 400) begin
            rk_ready = 1'($urandom_range(0, 1));
            if (nw % 4 == 2) begin
                load_valid = 1'b1;
                keys       = kb;
                decrypt    = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            tick();
            nw++;
        end
        load_valid = 1'b0;
        rk_ready   = 1'b1;
        chk("bp_done", 128'(!busy && sb.size() == 0), 128'd1);
        tick();
        chk("bp_no_reload", 128'(rk_valid), 128'd0);

        // Flush during beat 5 together with rk_ready.
        do_load(ka, 1'b0);
        repeat (5) tick();
        chk("flush_at_idx", 128'(rk_index), 128'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_rk_valid", 128'(rk_valid), 128'd0);
        chk("flush_load_ready", 128'(load_ready), 128'd1);
        chk("flush_busy", 128'(busy), 128'd0);
        chk("flush_sb_left", 128'(sb.size()), 128'd8);
        sb.delete();
        do_load(kb, 1'b1);
        chk("flush_reload_idx", 128'(rk_index), 128'd12);
        wait_done("flush_reload_done");

        // Reset at beat 7, then a fresh full stream.
        do_load(kb, 1'b0);
        repeat (7) tick();
        chk("rst_at_idx", 128'(rk_index), 128'd7);
        rst = 1'b1;
        tick();
        check_idle("rst_mid");
        rst = 1'b0;
        sb.delete();
        tick();
        do_load(ka, 1'b0);
        chk("rst_reload_rk", rk, K0);
        wait_done("rst_reload_done");

        // Back-to-back loads with load_valid held high and alternating direction.
        for (int n = 0; n < 4; n++) begin
            nw = 0;
            while (!load_ready && nw < 50) begin
                tick();
                nw++;
            end
            acc[n]     = cyc;
            keys       = (n % 2 == 1) ? kb : ka;
            decrypt    = (n % 2 == 1);
            load_valid = 1'b1;
            push_set(keys, decrypt);
            tick();
        end
        load_valid = 1'b0;
        wait_done("b2b_done");
        for (int n = 1; n < 4; n++) begin
            chk("b2b_period", 128'(acc[n] - acc[n-1]), 128'd14);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
